// File: rtl/barrel_coord_gen.sv
// rtl/barrel_coord_gen.sv - raster source-coordinate generator for radial (barrel) lens correction
// Optional macro BARREL_FRAME_MARKERS_EN adds Coord_SOF / Coord_EOL outputs.
module barrel_coord_gen #(
    parameter int IN_WIDTH   = 1080,
    parameter int IN_HEIGHT  = 960,
    parameter int OUT_WIDTH  = 1080,
    parameter int OUT_HEIGHT = 960,
    parameter int K_COEF     = -4000,
    parameter int R_SHIFT    = 8,
    localparam int MXW = $clog2(IN_WIDTH) + 1,
    localparam int MYW = $clog2(IN_HEIGHT) + 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           Pipe_En,
    input  logic           Math_Ready,
    output logic [MXW-1:0] Math_X,
    output logic [MYW-1:0] Math_Y,
    output logic           Coord_Valid,
`ifdef BARREL_FRAME_MARKERS_EN
    output logic           Coord_SOF,
    output logic           Coord_EOL,
`endif
    output logic           Frame_Done
);
    localparam int XW   = $clog2(OUT_WIDTH) + 1;
    localparam int YW   = $clog2(OUT_HEIGHT) + 1;
    localparam int DXW  = XW + 1;
    localparam int DYW  = YW + 1;
    localparam int SQXW = 2 * DXW;
    localparam int SQYW = 2 * DYW;
    localparam int RW   = ((SQXW > SQYW) ? SQXW : SQYW) + 1;
    localparam int KW   = 18;
    localparam int PW   = KW + RW + 1;
    localparam int SW   = (PW + 1 > 34) ? PW + 1 : 34;
    localparam int TXW  = DXW + SW + 1;
    localparam int TYW  = DYW + SW + 1;

    localparam logic [XW-1:0]         X_LAST    = XW'(OUT_WIDTH - 1);
    localparam logic [YW-1:0]         Y_LAST    = YW'(OUT_HEIGHT - 1);
    localparam logic signed [DXW-1:0] HALF_OW   = DXW'(OUT_WIDTH / 2);
    localparam logic signed [DYW-1:0] HALF_OH   = DYW'(OUT_HEIGHT / 2);
    localparam logic signed [KW-1:0]  K_S       = KW'(K_COEF);
    localparam logic signed [SW-1:0]  ONE_Q16   = SW'(65536);
    localparam logic signed [TXW-1:0] HALF_IW_T = TXW'(IN_WIDTH / 2);
    localparam logic signed [TYW-1:0] HALF_IH_T = TYW'(IN_HEIGHT / 2);
    localparam logic signed [TXW-1:0] MAX_X_T   = TXW'(IN_WIDTH - 1);
    localparam logic signed [TYW-1:0] MAX_Y_T   = TYW'(IN_HEIGHT - 1);

    logic adv;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    assign adv = Pipe_En & Math_Ready;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (adv) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // Stage 1: centred offsets and their squares
    logic signed [DXW-1:0]  dx_c;
    logic signed [DYW-1:0]  dy_c;
    logic signed [SQXW-1:0] dxe_c, dx2_c;
    logic signed [SQYW-1:0] dye_c, dy2_c;
    logic                   last_c;

    always_comb begin
        dx_c   = $signed({1'b0, x_q}) - HALF_OW;
        dy_c   = $signed({1'b0, y_q}) - HALF_OH;
        dxe_c  = SQXW'(dx_c);
        dye_c  = SQYW'(dy_c);
        dx2_c  = dxe_c * dxe_c;
        dy2_c  = dye_c * dye_c;
        last_c = (x_q == X_LAST) && (y_q == Y_LAST);
    end

    logic                  v1_q, last1_q;
    logic signed [DXW-1:0] dx1_q;
    logic signed [DYW-1:0] dy1_q;
    logic [SQXW-1:0]       dx2_q;
    logic [SQYW-1:0]       dy2_q;

    // Stage 2: r^2 and Q16 radial scale
    logic [RW-1:0]          r2_c;
    logic signed [PW-1:0]   k_ext_c, r2_ext_c, prod_c;
    logic signed [SW-1:0]   scale_c;

    always_comb begin
        r2_c     = RW'(dx2_q) + RW'(dy2_q);
        k_ext_c  = PW'(K_S);
        r2_ext_c = PW'(r2_c);
        prod_c   = k_ext_c * r2_ext_c;
        scale_c  = SW'(prod_c >>> R_SHIFT) + ONE_Q16;
    end

    logic                  v2_q, last2_q;
    logic signed [DXW-1:0] dx2s_q;
    logic signed [DYW-1:0] dy2s_q;
    logic signed [SW-1:0]  scale_q;

    // Stage 3: scaled offsets recentred on the source frame, then clamped
    logic signed [TXW-1:0] dxw_c, scx_c, mxp_c, sx_c;
    logic signed [TYW-1:0] dyw_c, scy_c, myp_c, sy_c;
    logic [MXW-1:0]        mx_d;
    logic [MYW-1:0]        my_d;

    always_comb begin
        dxw_c = TXW'(dx2s_q);
        scx_c = TXW'(scale_q);
        mxp_c = dxw_c * scx_c;
        sx_c  = (mxp_c >>> 16) + HALF_IW_T;
        dyw_c = TYW'(dy2s_q);
        scy_c = TYW'(scale_q);
        myp_c = dyw_c * scy_c;
        sy_c  = (myp_c >>> 16) + HALF_IH_T;
        if (sx_c[TXW-1])        mx_d = '0;
        else if (sx_c > MAX_X_T) mx_d = MXW'(IN_WIDTH - 1);
        else                     mx_d = sx_c[MXW-1:0];
        if (sy_c[TYW-1])        my_d = '0;
        else if (sy_c > MAX_Y_T) my_d = MYW'(IN_HEIGHT - 1);
        else                     my_d = sy_c[MYW-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            x_q         <= '0;
            y_q         <= '0;
            v1_q        <= 1'b0;
            last1_q     <= 1'b0;
            dx1_q       <= '0;
            dy1_q       <= '0;
            dx2_q       <= '0;
            dy2_q       <= '0;
            v2_q        <= 1'b0;
            last2_q     <= 1'b0;
            dx2s_q      <= '0;
            dy2s_q      <= '0;
            scale_q     <= '0;
            Math_X      <= '0;
            Math_Y      <= '0;
            Coord_Valid <= 1'b0;
            Frame_Done  <= 1'b0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            if (Pipe_En) begin
                v1_q        <= Math_Ready;
                last1_q     <= Math_Ready & last_c;
                dx1_q       <= dx_c;
                dy1_q       <= dy_c;
                dx2_q       <= dx2_c;
                dy2_q       <= dy2_c;
                v2_q        <= v1_q;
                last2_q     <= last1_q;
                dx2s_q      <= dx1_q;
                dy2s_q      <= dy1_q;
                scale_q     <= scale_c;
                Math_X      <= mx_d;
                Math_Y      <= my_d;
                Coord_Valid <= v2_q;
                Frame_Done  <= v2_q & last2_q;
            end
        end
    end

`ifdef BARREL_FRAME_MARKERS_EN
    logic sof1_q, eol1_q, sof2_q, eol2_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sof1_q    <= 1'b0;
            eol1_q    <= 1'b0;
            sof2_q    <= 1'b0;
            eol2_q    <= 1'b0;
            Coord_SOF <= 1'b0;
            Coord_EOL <= 1'b0;
        end else if (Pipe_En) begin
            sof1_q    <= Math_Ready & (x_q == '0) & (y_q == '0);
            eol1_q    <= Math_Ready & (x_q == X_LAST);
            sof2_q    <= sof1_q;
            eol2_q    <= eol1_q;
            Coord_SOF <= sof2_q;
            Coord_EOL <= eol2_q;
        end
    end
`endif

endmodule

// File: tb/tb_barrel_coord_gen.sv
// tb/tb_barrel_coord_gen.sv - self-checking bench for barrel_coord_gen (three coefficient sets)
module tb_barrel_coord_gen;
    localparam int OW = 8;
    localparam int OH = 4;
    localparam int IW = 8;
    localparam int IH = 4;

    typedef struct { int x; int y; } pix_t;
    typedef struct { int d; int px; int py; int ex; int ey; } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic pe = 1'b0;
    logic mr = 1'b0;
    logic [3:0] mx [3];
    logic [2:0] my [3];
    logic       cv [3];
    logic       fd [3];
`ifdef BARREL_FRAME_MARKERS_EN
    logic       sof [3];
    logic       eol [3];
`endif

    int checks = 0;
    int errors = 0;
    int bubbles = 0;
    pix_t sbq[$];
    int bx = 0, by = 0, last_ax = -1, last_ay = -1;
    logic pe_last = 1'b0, rst_last = 1'b0;
    int got_x [3][OW][OH];
    int got_y [3][OW][OH];
    bit got_v [3][OW][OH];
    longint ks [3] = '{0, -1638, 16384};
    int rss [3] = '{8, 0, 0};

    always #5 clk = ~clk;

    barrel_coord_gen #(.IN_WIDTH(IW), .IN_HEIGHT(IH), .OUT_WIDTH(OW), .OUT_HEIGHT(OH),
                       .K_COEF(0), .R_SHIFT(8)) dut0 (
        .clk(clk), .reset(reset), .Pipe_En(pe), .Math_Ready(mr),
        .Math_X(mx[0]), .Math_Y(my[0]), .Coord_Valid(cv[0]),
`ifdef BARREL_FRAME_MARKERS_EN
        .Coord_SOF(sof[0]), .Coord_EOL(eol[0]),
`endif
        .Frame_Done(fd[0]));

    barrel_coord_gen #(.IN_WIDTH(IW), .IN_HEIGHT(IH), .OUT_WIDTH(OW), .OUT_HEIGHT(OH),
                       .K_COEF(-1638), .R_SHIFT(0)) dut1 (
        .clk(clk), .reset(reset), .Pipe_En(pe), .Math_Ready(mr),
        .Math_X(mx[1]), .Math_Y(my[1]), .Coord_Valid(cv[1]),
`ifdef BARREL_FRAME_MARKERS_EN
        .Coord_SOF(sof[1]), .Coord_EOL(eol[1]),
`endif
        .Frame_Done(fd[1]));

    barrel_coord_gen #(.IN_WIDTH(IW), .IN_HEIGHT(IH), .OUT_WIDTH(OW), .OUT_HEIGHT(OH),
                       .K_COEF(16384), .R_SHIFT(0)) dut2 (
        .clk(clk), .reset(reset), .Pipe_En(pe), .Math_Ready(mr),
        .Math_X(mx[2]), .Math_Y(my[2]), .Coord_Valid(cv[2]),
`ifdef BARREL_FRAME_MARKERS_EN
        .Coord_SOF(sof[2]), .Coord_EOL(eol[2]),
`endif
        .Frame_Done(fd[2]));

    task automatic check(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic void model(input int x, input int y, input longint k, input int rs,
                                  output int sx, output int sy);
        longint dx, dy, r2, sc, tx, ty;
        dx = x - OW / 2;
        dy = y - OH / 2;
        r2 = dx * dx + dy * dy;
        sc = 65536 + ((k * r2) >>> rs);
        tx = IW / 2 + ((dx * sc) >>> 16);
        ty = IH / 2 + ((dy * sc) >>> 16);
        if (tx < 0) tx = 0;
        if (tx > IW - 1) tx = IW - 1;
        if (ty < 0) ty = 0;
        if (ty > IH - 1) ty = IH - 1;
        sx = int'(tx);
        sy = int'(ty);
    endfunction

    // Expected pixel order: push on every accepted raster step
    always @(posedge clk) begin
        pe_last  <= pe;
        rst_last <= reset;
        if (!reset) begin
            sbq.delete();
            bx <= 0;
            by <= 0;
        end else if (pe && mr) begin
            sbq.push_back('{bx, by});
            last_ax <= bx;
            last_ay <= by;
            if (bx == OW - 1) begin
                bx <= 0;
                by <= (by == OH - 1) ? 0 : by + 1;
            end else begin
                bx <= bx + 1;
            end
        end
    end

    always @(negedge clk) begin
        pix_t e;
        int ex, ey;
        if (pe_last && rst_last) begin
            if (cv[0]) begin
                if (sbq.size() == 0) begin
                    check(1'b0, "sb_underflow", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    for (int d = 0; d < 3; d++) begin
                        model(e.x, e.y, ks[d], rss[d], ex, ey);
                        check(cv[d] && int'(mx[d]) == ex && int'(my[d]) == ey, "coord",
                              int'(mx[d]) * 100 + int'(my[d]), ex * 100 + ey);
                        check(fd[d] == (e.x == OW - 1 && e.y == OH - 1), "frame_done",
                              int'(fd[d]), int'(e.x == OW - 1 && e.y == OH - 1));
                        got_x[d][e.x][e.y] = int'(mx[d]);
                        got_y[d][e.x][e.y] = int'(my[d]);
                        got_v[d][e.x][e.y] = 1'b1;
                    end
`ifdef BARREL_FRAME_MARKERS_EN
                    check(sof[0] == (e.x == 0 && e.y == 0), "sof", int'(sof[0]), int'(e.x == 0 && e.y == 0));
                    check(eol[0] == (e.x == OW - 1), "eol", int'(eol[0]), int'(e.x == OW - 1));
`endif
                end
            end else begin
                bubbles++;
                check(!fd[0], "fd_on_bubble", int'(fd[0]), 0);
            end
        end
    end

    task automatic wait_out(input int x, input int y, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk);
            #1;
            ok = cv[0] && int'(mx[0]) == x && int'(my[0]) == y;
        end
        check(ok, name, int'(mx[0]) * 100 + int'(my[0]), x * 100 + y);
    endtask

    task automatic latency_check(input string tag);
        reset = 1'b1;
        pe = 1'b1;
        mr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check(!cv[0], {tag, "_lat_early"}, int'(cv[0]), 0);
        @(posedge clk);
        #1;
        check(cv[0] && mx[0] == 0 && my[0] == 0, {tag, "_lat3"},
              int'(cv[0]) * 10000 + int'(mx[0]) * 100 + int'(my[0]), 10000);
    endtask

    initial begin
        vec_t tbl [5];
        tbl[0] = '{1, 0, 0, 1, 0};
        tbl[1] = '{1, 4, 2, 4, 2};
        tbl[2] = '{2, 0, 0, 0, 0};
        tbl[3] = '{2, 7, 3, 7, 3};
        tbl[4] = '{0, 5, 1, 5, 1};

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++)
            check(!cv[d] && !fd[d] && mx[d] == 0 && my[d] == 0, "reset_state",
                  int'(cv[d]) + int'(fd[d]) + int'(mx[d]) + int'(my[d]), 0);

        latency_check("start");
        check(last_ax == 2 && last_ay == 0, "accepted_2_0", last_ax * 100 + last_ay, 200);

        mr = 1'b0;
        bubbles = 0;
        repeat (5) @(posedge clk);
        #1;
        mr = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check(bubbles == 5, "stall_bubbles", bubbles, 5);

        wait_out(5, 1, "reach_5_1");
        pe = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check(cv[0] && mx[0] == 5 && my[0] == 1, "pe_hold",
                  int'(cv[0]) * 10000 + int'(mx[0]) * 100 + int'(my[0]), 10501);
        end
        pe = 1'b1;

        wait_out(7, 3, "reach_7_3");
        check(fd[0], "fd_last", int'(fd[0]), 1);
        @(posedge clk);
        #1;
        check(cv[0] && mx[0] == 0 && my[0] == 0 && !fd[0], "wrap_0_0",
              int'(mx[0]) * 100 + int'(my[0]), 0);

        wait_out(3, 2, "reach_3_2");
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++)
            check(!cv[d] && !fd[d] && mx[d] == 0 && my[d] == 0, "midframe_reset",
                  int'(cv[d]) + int'(fd[d]) + int'(mx[d]) + int'(my[d]), 0);
        latency_check("restart");

        repeat (10) @(posedge clk);
        #1;
        mr = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check(sbq.size() == 0, "drain_empty", sbq.size(), 0);

        for (int i = 0; i < 5; i++)
            check(got_v[tbl[i].d][tbl[i].px][tbl[i].py] &&
                  got_x[tbl[i].d][tbl[i].px][tbl[i].py] == tbl[i].ex &&
                  got_y[tbl[i].d][tbl[i].px][tbl[i].py] == tbl[i].ey, "table_vec",
                  got_x[tbl[i].d][tbl[i].px][tbl[i].py] * 100 + got_y[tbl[i].d][tbl[i].px][tbl[i].py],
                  tbl[i].ex * 100 + tbl[i].ey);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
